// File: rtl/heho_pkg.sv
// ---------------------------------------------------------------------------
// heho_pkg
//   Shared constants and types for the half-even/half-odd count stream
//   checker. The stream runs 0,2,...,50 then 51,53,...,99 and wraps to 0.
//
//   Contents:
//     EVEN_MAX, ODD_MIN, ODD_MAX, STEP : stream boundary constants
//     state_e                          : checker lock state (HUNT/SYNC/LOCK)
// ---------------------------------------------------------------------------
package heho_pkg;

  localparam logic [7:0] EVEN_MAX = 8'd50;
  localparam logic [7:0] ODD_MIN  = 8'd51;
  localparam logic [7:0] ODD_MAX  = 8'd99;
  localparam logic [7:0] STEP     = 8'd2;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_e;

endpackage : heho_pkg

// File: rtl/heho_next_val.sv
// ---------------------------------------------------------------------------
// heho_next_val
//   Purely combinational successor/legality function for the count stream.
//
//   Ports:
//     v     in  [7:0]  value to classify
//     nxt   out [7:0]  successor of v in the stream (99->0, 50->51, else +2)
//     legal out        v is a member of the stream (even <=50, or odd 51..99)
//
//   nxt is only meaningful when legal is high; for legal inputs the +2 never
//   overflows 8 bits.
// ---------------------------------------------------------------------------
module heho_next_val
  import heho_pkg::*;
(
  input  logic [7:0] v,
  output logic [7:0] nxt,
  output logic       legal
);

  always_comb begin
    legal = v[0] ? ((v >= ODD_MIN) && (v <= ODD_MAX)) : (v <= EVEN_MAX);

    if (v == ODD_MAX) begin
      nxt = 8'd0;
    end else if (v == EVEN_MAX) begin
      nxt = ODD_MIN;
    end else begin
      nxt = v + STEP;
    end
  end

endmodule : heho_next_val

// File: rtl/heho_seq_checker.sv
// ---------------------------------------------------------------------------
// heho_seq_checker
//   Receive-side integrity checker for the half-even/half-odd count stream.
//   Hunts for a legal sample, confirms LOCK_CNT consecutive in-sequence
//   samples, then tracks the expected value. While locked, mismatches pulse
//   err and bump a saturating error counter; LOSS_CNT consecutive misses drop
//   back to HUNT. Matched 99 samples while locked count full-sequence wraps.
//
//   Parameters:
//     LOCK_CNT (2..15) : in-sequence samples needed to declare lock
//     LOSS_CNT (1..15) : consecutive locked misses that force loss of lock
//     ERR_W            : width of the saturating error counter
//
//   Ports:
//     clk      in              rising-edge clock
//     rst      in              synchronous active-high reset
//     in_valid in              in_cnt carries a sample this cycle
//     in_cnt   in  [7:0]       sampled count value
//     clr_err  in              synchronous clear of err_cnt
//     locked   out             high while in LOCK
//     err      out             one-cycle pulse per mismatch while locked
//     err_cnt  out [ERR_W-1:0] saturating mismatch count
//     wrap_cnt out [15:0]      matched 99 samples while locked (mod 2^16)
//     expected out [7:0]       value expected on the next valid sample
//
//   Build option:
//     HEHO_CHK_RESYNC_EN : when defined, a locked mismatch with a legal sample
//                          re-aligns expected to next(in_cnt) instead of
//                          flywheeling on next(expected).
// ---------------------------------------------------------------------------
module heho_seq_checker
  import heho_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_cnt,
  input  logic             clr_err,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [15:0]      wrap_cnt,
  output logic [7:0]       expected
);

  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0]       LOSS_TGT = 4'(LOSS_CNT);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic [7:0]       exp_q, exp_d;
  logic [3:0]       match_run_q, match_run_d;
  logic [3:0]       miss_run_q, miss_run_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [15:0]      wrap_cnt_q, wrap_cnt_d;

  logic [7:0] in_nxt, exp_nxt;
  logic       in_legal, exp_legal;
  logic       in_match;
  logic [3:0] match_inc, miss_inc;

  heho_next_val u_next_in (
    .v     (in_cnt),
    .nxt   (in_nxt),
    .legal (in_legal)
  );

  heho_next_val u_next_exp (
    .v     (exp_q),
    .nxt   (exp_nxt),
    .legal (exp_legal)
  );

  // A sample only counts as in-sequence against a legal expected value, so a
  // corrupted expected register can never be "matched" back into lock.
  assign in_match  = (in_cnt == exp_q) && exp_legal;
  assign match_inc = match_run_q + 4'd1;
  assign miss_inc  = miss_run_q + 4'd1;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    err_d       = 1'b0;
    wrap_cnt_d  = wrap_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_legal) begin
            state_d     = SYNC;
            exp_d       = in_nxt;
            match_run_d = 4'd1;
          end
        end

        SYNC: begin
          if (in_match) begin
            exp_d       = exp_nxt;
            match_run_d = match_inc;
            if (match_inc == LOCK_TGT) begin
              state_d    = LOCK;
              miss_run_d = 4'd0;
            end
          end else if (in_legal) begin
            // Restart the confirmation run from this sample.
            exp_d       = in_nxt;
            match_run_d = 4'd1;
          end else begin
            state_d     = HUNT;
            match_run_d = 4'd0;
          end
        end

        LOCK: begin
          if (in_match) begin
            exp_d      = exp_nxt;
            miss_run_d = 4'd0;
            if (in_cnt == ODD_MAX) begin
              wrap_cnt_d = wrap_cnt_q + 16'd1;
            end
          end else begin
            err_d      = 1'b1;
            miss_run_d = miss_inc;
`ifdef HEHO_CHK_RESYNC_EN
            exp_d      = in_legal ? in_nxt : exp_nxt;
`else
            exp_d      = exp_nxt;
`endif
            if (miss_inc == LOSS_TGT) begin
              state_d     = HUNT;
              miss_run_d  = 4'd0;
              match_run_d = 4'd0;
            end
          end
        end

        default: begin
          state_d     = HUNT;
          match_run_d = 4'd0;
          miss_run_d  = 4'd0;
        end
      endcase
    end

    // Clear wins over accumulation, but an error in the clearing cycle is
    // still counted.
    if (clr_err) begin
      err_cnt_d = err_d ? ERR_ONE : '0;
    end else if (err_d && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of all others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      exp_q       <= 8'd0;
      match_run_q <= 4'd0;
      miss_run_q  <= 4'd0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      match_run_q <= match_run_d;
      miss_run_q  <= miss_run_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
    end
  end

  assign locked   = (state_q == LOCK);
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign wrap_cnt = wrap_cnt_q;
  assign expected = exp_q;

endmodule : heho_seq_checker

// File: tb/tb_heho_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_heho_seq_checker
//   Directed bench for heho_seq_checker. Two instances share the stimulus:
//   dut with default parameters, and dut2 with ERR_W=2 to exercise error
//   counter saturation. Expected values are hand-derived from the stream
//   definition (0,2,..,50,51,53,..,99,0,..).
// ---------------------------------------------------------------------------
module tb_heho_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_cnt;
  logic       clr_err;

  logic        locked, err;
  logic [7:0]  err_cnt;
  logic [15:0] wrap_cnt;
  logic [7:0]  expected;

  logic        locked2, err2;
  logic [1:0]  err_cnt2;
  logic [15:0] wrap_cnt2;
  logic [7:0]  expected2;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_m;

  always #5 clk = ~clk;

  heho_seq_checker dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_cnt   (in_cnt),
    .clr_err  (clr_err),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .wrap_cnt (wrap_cnt),
    .expected (expected)
  );

  heho_seq_checker #(.ERR_W(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_cnt   (in_cnt),
    .clr_err  (clr_err),
    .locked   (locked2),
    .err      (err2),
    .err_cnt  (err_cnt2),
    .wrap_cnt (wrap_cnt2),
    .expected (expected2)
  );

  // Reference successor function of the stream.
  function automatic logic [7:0] nxt(input logic [7:0] v);
    if (v == 8'd99) return 8'd0;
    if (v == 8'd50) return 8'd51;
    return v + 8'd2;
  endfunction

  // Present one sample for one clock; outputs are examined 1 time unit after
  // the capturing edge, then inputs return to idle.
  task automatic step(input logic valid, input logic [7:0] v, input logic clr);
    @(negedge clk);
    in_valid = valid;
    in_cnt   = v;
    clr_err  = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_err  = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;   // must be ignored while in reset
    in_cnt   = 8'd0;
    clr_err  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b want=0", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b want=0", err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
    checks++; if (wrap_cnt !== 16'd0) begin errors++; $display("FAIL reset_wrap_cnt got=%0d want=0", wrap_cnt); end
    checks++; if (expected !== 8'd0) begin errors++; $display("FAIL reset_expected got=%0d want=0", expected); end
  endtask

  task automatic test_lock;
    step(1'b1, 8'd0, 1'b0);
    checks++; if (expected !== 8'd2) begin errors++; $display("FAIL hunt_to_sync_expected got=%0d want=2", expected); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sync_not_locked got=%0b want=0", locked); end
    step(1'b1, 8'd2, 1'b0);
    step(1'b1, 8'd4, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL early_lock got=%0b want=0", locked); end
    step(1'b1, 8'd6, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_after_6 got=%0b want=1", locked); end
    checks++; if (expected !== 8'd8) begin errors++; $display("FAIL lock_expected got=%0d want=8", expected); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL lock_err_cnt got=%0d want=0", err_cnt); end
  endtask

  task automatic test_wrap;
    int err_seen;
    logic [7:0] mid [4];
    mid = '{8'd48, 8'd50, 8'd51, 8'd53};
    err_seen = 0;
    for (int v = 8; v <= 46; v += 2) begin
      step(1'b1, 8'(v), 1'b0);
      err_seen += int'(err);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, mid[i], 1'b0);
      err_seen += int'(err);
    end
    checks++; if (expected !== 8'd55) begin errors++; $display("FAIL even_odd_boundary_expected got=%0d want=55", expected); end
    for (int v = 55; v <= 99; v += 2) begin
      step(1'b1, 8'(v), 1'b0);
      err_seen += int'(err);
    end
    checks++; if (wrap_cnt !== 16'd1) begin errors++; $display("FAIL wrap_after_99 got=%0d want=1", wrap_cnt); end
    step(1'b1, 8'd0, 1'b0);
    err_seen += int'(err);
    checks++; if (err_seen !== 0) begin errors++; $display("FAIL wrap_no_err got=%0d pulses want=0", err_seen); end
    checks++; if (expected !== 8'd2) begin errors++; $display("FAIL wrap_expected got=%0d want=2", expected); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wrap_locked got=%0b want=1", locked); end
  endtask

  task automatic test_flywheel;
    for (int v = 2; v <= 18; v += 2) step(1'b1, 8'(v), 1'b0);
    checks++; if (expected !== 8'd20) begin errors++; $display("FAIL fly_setup_expected got=%0d want=20", expected); end
    step(1'b1, 8'd7, 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL fly_err_pulse got=%0b want=1", err); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL fly_err_cnt got=%0d want=1", err_cnt); end
    checks++; if (expected !== 8'd22) begin errors++; $display("FAIL fly_expected got=%0d want=22", expected); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL fly_locked got=%0b want=1", locked); end
    checks++; if (err_cnt2 !== 2'd1) begin errors++; $display("FAIL fly_err_cnt2 got=%0d want=1", err_cnt2); end
    step(1'b0, 8'd55, 1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL idle_err got=%0b want=0", err); end
    checks++; if (expected !== 8'd22) begin errors++; $display("FAIL idle_expected got=%0d want=22", expected); end
    step(1'b1, 8'd22, 1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL fly_recover_err got=%0b want=0", err); end
    checks++; if (expected !== 8'd24) begin errors++; $display("FAIL fly_recover_expected got=%0d want=24", expected); end
    step(1'b1, 8'd30, 1'b0);
`ifdef HEHO_CHK_RESYNC_EN
    exp_m = 8'd32;
`else
    exp_m = 8'd26;
`endif
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL legal_miss_err got=%0b want=1", err); end
    checks++; if (expected !== exp_m) begin errors++; $display("FAIL legal_miss_expected got=%0d want=%0d", expected, exp_m); end
    checks++; if (err_cnt2 !== 2'd2) begin errors++; $display("FAIL legal_miss_err_cnt2 got=%0d want=2", err_cnt2); end
    step(1'b1, exp_m, 1'b0);
    exp_m = exp_m + 8'd2;
    checks++; if (expected !== exp_m) begin errors++; $display("FAIL legal_miss_follow got=%0d want=%0d", expected, exp_m); end
  endtask

  task automatic test_loss;
    logic want_lock;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd7, 1'b0);
      exp_m     = exp_m + 8'd2;
      want_lock = (i < 2);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL loss_err_%0d got=%0b want=1", i, err); end
      checks++; if (locked !== want_lock) begin errors++; $display("FAIL loss_locked_%0d got=%0b want=%0b", i, locked, want_lock); end
    end
    checks++; if (err_cnt !== 8'd5) begin errors++; $display("FAIL loss_err_cnt got=%0d want=5", err_cnt); end
    checks++; if (err_cnt2 !== 2'd3) begin errors++; $display("FAIL err_cnt2_saturate got=%0d want=3", err_cnt2); end
    checks++; if (expected !== exp_m) begin errors++; $display("FAIL loss_expected got=%0d want=%0d", expected, exp_m); end
    step(1'b1, 8'd10, 1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL hunt_no_err got=%0b want=0", err); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL resync_locked got=%0b want=0", locked); end
    checks++; if (expected !== 8'd12) begin errors++; $display("FAIL resync_expected got=%0d want=12", expected); end
  endtask

  task automatic test_clr;
    step(1'b1, 8'd12, 1'b0);
    step(1'b1, 8'd14, 1'b0);
    step(1'b1, 8'd16, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock got=%0b want=1", locked); end
    step(1'b1, 8'd5, 1'b1);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL clr_err_pulse got=%0b want=1", err); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL clr_with_err got=%0d want=1", err_cnt); end
    checks++; if (err_cnt2 !== 2'd1) begin errors++; $display("FAIL clr_with_err2 got=%0d want=1", err_cnt2); end
    step(1'b1, 8'd20, 1'b1);
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL clr_alone got=%0d want=0", err_cnt); end
    checks++; if (expected !== 8'd22) begin errors++; $display("FAIL clr_expected got=%0d want=22", expected); end
  endtask

  task automatic test_rst_mid_lock;
    logic [7:0] v;
    int wraps;
    v     = 8'd22;
    wraps = 1;
    for (int k = 0; k < 400 && wraps < 5; k++) begin
      step(1'b1, v, 1'b0);
      if (v == 8'd99) wraps++;
      v = nxt(v);
    end
    checks++; if (wrap_cnt !== 16'd5) begin errors++; $display("FAIL wrap_five got=%0d want=5", wrap_cnt); end
    step(1'b1, 8'd7, 1'b0);
    step(1'b1, 8'd7, 1'b0);
    v = nxt(nxt(v));
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL pre_rst_err_cnt got=%0d want=2", err_cnt); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL pre_rst_locked got=%0b want=1", locked); end
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_cnt   = v;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_rst_locked got=%0b want=0", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_rst_err got=%0b want=0", err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_err_cnt got=%0d want=0", err_cnt); end
    checks++; if (wrap_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_wrap_cnt got=%0d want=0", wrap_cnt); end
    checks++; if (expected !== 8'd0) begin errors++; $display("FAIL mid_rst_expected got=%0d want=0", expected); end
    // Back in HUNT: an illegal sample is ignored, then a fresh run with a
    // legal mid-run restart needs a full LOCK_CNT run again.
    step(1'b1, 8'd7, 1'b0);
    checks++; if (expected !== 8'd0) begin errors++; $display("FAIL hunt_illegal_expected got=%0d want=0", expected); end
    step(1'b1, 8'd0, 1'b0);
    step(1'b1, 8'd2, 1'b0);
    step(1'b1, 8'd40, 1'b0);
    checks++; if (expected !== 8'd42) begin errors++; $display("FAIL sync_restart_expected got=%0d want=42", expected); end
    step(1'b1, 8'd42, 1'b0);
    step(1'b1, 8'd44, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sync_restart_early_lock got=%0b want=0", locked); end
    step(1'b1, 8'd46, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sync_restart_lock got=%0b want=1", locked); end
    checks++; if (expected !== 8'd48) begin errors++; $display("FAIL sync_restart_lock_expected got=%0d want=48", expected); end
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_cnt   = 8'd0;
    clr_err  = 1'b0;
    test_reset();
    test_lock();
    test_wrap();
    test_flywheel();
    test_loss();
    test_clr();
    test_rst_mid_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_heho_seq_checker
